// File: rtl/uart_word_loader.sv
// uart_word_loader
//   Boot-path front end. Receives 8N1 UART bytes (LSB first) on rxd, packs them
//   little-endian into 32-bit words and queues each word with a running word
//   address in a small FIFO. The FIFO drains over a valid/ready handshake.
//
// Ports
//   sys_clock   in   clock, rising edge
//   reset       in   asynchronous, active-low
//   rxd         in   raw UART line, asynchronous, idles high
//   word_data   out  word at the FIFO head, byte k in bits [8k+7:8k]
//   word_addr   out  word index of the FIFO head entry
//   word_valid  out  FIFO not empty
//   word_ready  in   consumer takes the head word when word_valid && word_ready
//   busy        out  receiver not idle, or a partial word is being assembled
//   frame_err   out  one-cycle pulse on a bad stop bit
//   overflow    out  sticky, a completed word was dropped on a full FIFO
//   done        out  one-cycle pulse when the announced length has been loaded
//
// Build option
//   UART_LOADER_LEN_HDR_EN  first 4 bytes after reset give the payload length in
//                           bytes; the tail is zero-padded and done pulses. When
//                           undefined there is no header and done is tied to 0.
//
// RX states
//   state   | meaning
//   IDLE    | line high, waiting for a start edge
//   START   | timing to mid start bit, rejects glitches
//   DATA    | sampling 8 data bits, one per bit time
//   STOP    | sampling the stop bit
//   WAIT_HI | bad stop bit seen, waiting for the line to return high

module uart_word_loader #(
  parameter int CLKS_PER_BIT = 5,
  parameter int FIFO_DEPTH   = 4,
  parameter int ADDR_W       = 16
) (
  input  logic              sys_clock,
  input  logic              reset,
  input  logic              rxd,
  output logic [31:0]       word_data,
  output logic [ADDR_W-1:0] word_addr,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output logic              frame_err,
  output logic              overflow,
  output logic              done
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] FULL_LD = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LD = TW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} rx_state_t;

  logic            rx_meta, rxs;
  rx_state_t       state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_stb, bad_stop;

  logic [1:0]      lane_q;
  logic [31:0]     buf_q, asm_word;
  logic            accept, push, hdr_cap;

  logic [31:0]       mem_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
  logic [PW:0]       wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] addr_cnt;
  logic              full, empty, pop;

  // two-flop synchroniser, idles high so reset does not look like a start bit
  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // the bit timer counts down; every sample is taken at terminal count
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    byte_stb = 1'b0;
    bad_stop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          timer_d = HALF_LD;
          bit_d   = '0;
        end
      end
      START: begin
        if (timer_q == '0) begin
          if (rxs) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            timer_d = FULL_LD;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      DATA: begin
        if (timer_q == '0) begin
          shift_d = {rxs, shift_q[7:1]};
          timer_d = FULL_LD;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      STOP: begin
        if (timer_q == '0) begin
          if (rxs) begin
            byte_stb = 1'b1;
            state_d  = IDLE;
          end else begin
            bad_stop = 1'b1;
            state_d  = WAIT_HI;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      WAIT_HI: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // current partial word with the freshly received byte dropped into its lane
  always_comb begin
    asm_word = buf_q;
    asm_word[{lane_q, 3'b000} +: 8] = shift_q;
  end

`ifdef UART_LOADER_LEN_HDR_EN
  logic        hdr_done_q, finished_q, zero_pend_q, hit_len, take;
  logic [31:0] len_q, cnt_q;

  always_comb begin
    hdr_cap = byte_stb && !hdr_done_q && (lane_q == 2'd3);
    take    = byte_stb && hdr_done_q && !finished_q;
    hit_len = take && ((cnt_q + 32'd1) == len_q);
    push    = take && ((lane_q == 2'd3) || hit_len);
    accept  = byte_stb && !finished_q;
  end

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      hdr_done_q  <= 1'b0;
      finished_q  <= 1'b0;
      zero_pend_q <= 1'b0;
      len_q       <= '0;
      cnt_q       <= '0;
      done        <= 1'b0;
    end else begin
      zero_pend_q <= hdr_cap && (asm_word == 32'd0);
      // done lands with word_valid of the final push, or one cycle after an empty header
      done        <= hit_len || zero_pend_q;
      if (hdr_cap) begin
        hdr_done_q <= 1'b1;
        len_q      <= asm_word;
        if (asm_word == 32'd0) finished_q <= 1'b1;
      end
      if (take) cnt_q <= cnt_q + 32'd1;
      if (hit_len) finished_q <= 1'b1;
    end
  end
`else
  always_comb begin
    hdr_cap = 1'b0;
    accept  = byte_stb;
    push    = byte_stb && (lane_q == 2'd3);
  end

  assign done = 1'b0;
`endif

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop   = !empty && word_ready;

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      lane_q    <= '0;
      buf_q     <= '0;
      addr_cnt  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_addr[i] <= '0;
      end
    end else begin
      frame_err <= bad_stop;
      if (push || hdr_cap) begin
        lane_q <= '0;
        buf_q  <= '0;
      end else if (accept) begin
        lane_q <= lane_q + 2'd1;
        buf_q  <= asm_word;
      end
      // the address advances even when the word is dropped, so the consumer can see the gap
      if (push) begin
        addr_cnt <= addr_cnt + 1'b1;
        if (!full || pop) begin
          mem_data[wr_ptr[PW-1:0]] <= asm_word;
          mem_addr[wr_ptr[PW-1:0]] <= addr_cnt;
          wr_ptr <= wr_ptr + 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign word_valid = !empty;
  assign word_data  = mem_data[rd_ptr[PW-1:0]];
  assign word_addr  = mem_addr[rd_ptr[PW-1:0]];
  assign busy       = (state_q != IDLE) || (lane_q != 2'd0);

endmodule
